// File: rtl/boot_flash_responder.sv
// Boot-flash read responder with a NOR-style provisioning port (sector erase, word program)
// and a sticky write-protect lock. Reads have fixed 1-cycle latency and no valid strobe.
module boot_flash_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          DEPTH_WORDS  = 256,
    parameter int          SECTOR_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] flash_addr,
    input  logic        flash_read_en,
    output logic [31:0] flash_data,
    output logic        read_error,
    output logic        flash_busy,
    input  logic        pgm_req,
    input  logic        erase_req,
    input  logic [31:0] pgm_addr,
    input  logic [31:0] pgm_wdata,
    input  logic        lock,
    output logic        locked,
    output logic        pgm_ack,
    output logic        pgm_error
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam int          SW   = $clog2(SECTOR_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    typedef enum logic [2:0] {IDLE, PROG, ERASE, ACK, WAIT_REL} state_t;

    state_t          state, state_nx;
    logic [SW-1:0]   er_cnt;
    logic [AW-1:0]   op_idx;
    logic [31:0]     op_wdata;
    logic            op_err;
    logic            accept;
    logic            acc_err;

    // The array holds the complement of each word, so a zero-initialised array reads as
    // erased (all 1s) without any reset or initial block on the storage.
    logic [31:0]     mem_n [DEPTH_WORDS];

    // Subtraction wraps addresses below BASE_ADDR to huge offsets, so one compare rejects both sides.
    logic [31:0]     rd_off, pg_off;
    logic            rd_valid, pg_valid;
    logic [AW-1:0]   rd_idx, pg_idx, er_idx;

    assign rd_off   = flash_addr - BASE_ADDR;
    assign pg_off   = pgm_addr - BASE_ADDR;
    assign rd_valid = (rd_off < SPAN) && (flash_addr[1:0] == 2'b00);
    assign pg_valid = (pg_off < SPAN) && (pgm_addr[1:0] == 2'b00);
    assign rd_idx   = rd_off[AW+1:2];
    assign pg_idx   = pg_off[AW+1:2];
    assign er_idx   = op_idx | AW'(er_cnt);

    assign flash_busy = (state == PROG) || (state == ERASE);
    assign pgm_ack    = (state == ACK);
    assign pgm_error  = (state == ACK) && op_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        acc_err  = 1'b0;
        case (state)
            IDLE: begin
                if (!flash_read_en && (erase_req || pgm_req)) begin
                    accept = 1'b1;
                    if (locked || !pg_valid) begin
                        acc_err  = 1'b1;
                        state_nx = ACK;
                    end else if (erase_req) begin
                        state_nx = ERASE;
                    end else begin
                        state_nx = PROG;
                    end
                end
            end
            PROG:     state_nx = ACK;
            ERASE:    if (er_cnt == SW'(SECTOR_WORDS - 1)) state_nx = ACK;
            ACK:      state_nx = WAIT_REL;
            WAIT_REL: if (!pgm_req && !erase_req) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            er_cnt   <= '0;
            op_idx   <= '0;
            op_wdata <= '0;
            op_err   <= 1'b0;
            locked   <= 1'b0;
        end else begin
            if (lock) locked <= 1'b1;
            er_cnt <= (state == ERASE) ? er_cnt + 1'b1 : '0;
            if (accept) begin
                op_err   <= acc_err;
                op_wdata <= pgm_wdata;
                // Erase keeps only the sector base; the counter fills in the low bits.
                op_idx   <= erase_req ? (pg_idx & ~AW'(SECTOR_WORDS - 1)) : pg_idx;
            end
        end
    end

    // Nonvolatile storage: no reset. Program can only clear bits (set bits of the complement).
    always_ff @(posedge clk) begin
        if (state == PROG)       mem_n[op_idx] <= mem_n[op_idx] | ~op_wdata;
        else if (state == ERASE) mem_n[er_idx] <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_data <= '0;
            read_error <= 1'b0;
        end else begin
            read_error <= 1'b0;
            if (flash_read_en) begin
                if (rd_valid && state == IDLE) begin
                    flash_data <= ~mem_n[rd_idx];
                end else begin
                    flash_data <= '1;
                    read_error <= 1'b1;
                end
            end
        end
    end

endmodule
